// File: rtl/ising_run_ctrl.sv
// ising_run_ctrl: run controller for the Ising core and its sampler.
//   Collects a weight image from a narrow config stream into a shadow
//   register. On start it commits the image to the core, holds the core in
//   reset for a settle window, releases it for a programmed number of cycles,
//   then returns the final phase vector and a phase-activity count.
// Ports:
//   clk, rstn                  clock, async active-low reset
//   cfg_valid/cfg_ready/cfg_data  config word stream (accepted only in IDLE)
//   cfg_loaded                 a full image has been received since reset
//   start, run_cycles, abort   run control (run_cycles latched at start)
//   busy                       controller not idle
//   weights, ising_rstn        drive the Ising core
//   phase                      sampled phase vector from the sampler
//   res_valid/res_ready, res_phase, res_flips  result port
module ising_run_ctrl #(
  parameter int unsigned N             = 3,
  parameter int unsigned NUM_WEIGHTS   = 5,
  parameter int unsigned WORD_W        = 8,
  parameter int unsigned RUN_W         = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned FLIP_W        = 8,
  localparam int unsigned WB = $clog2(NUM_WEIGHTS) * (N * (N - 1) / 2),
  localparam int unsigned NW = (WB + WORD_W - 1) / WORD_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_loaded,
  input  logic              start,
  input  logic [RUN_W-1:0]  run_cycles,
  input  logic              abort,
  output logic              busy,
  output logic [WB-1:0]     weights,
  output logic              ising_rstn,
  input  logic [N-1:0]      phase,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      res_phase,
  output logic [FLIP_W-1:0] res_flips
);

  localparam int unsigned IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned DW_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NW - 1);
  localparam logic [SC_W-1:0]   LAST_SETTLE = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [FLIP_W-1:0] FLIP_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [WB-1:0]     shadow_q, shadow_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic              cfg_loaded_q, cfg_loaded_d;
  logic [WB-1:0]     weights_q, weights_d;
  logic              ising_rstn_q, ising_rstn_d;
  logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [RUN_W-1:0]  run_rem_q, run_rem_d;
  logic [N-1:0]      prev_phase_q, prev_phase_d;
  logic              res_valid_q, res_valid_d;
  logic [N-1:0]      res_phase_q, res_phase_d;
  logic [FLIP_W-1:0] res_flips_q, res_flips_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      word_idx_q   <= '0;
      cfg_loaded_q <= 1'b0;
      weights_q    <= '0;
      ising_rstn_q <= 1'b0;
      settle_cnt_q <= '0;
      run_rem_q    <= '0;
      prev_phase_q <= '0;
      res_valid_q  <= 1'b0;
      res_phase_q  <= '0;
      res_flips_q  <= '0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      word_idx_q   <= word_idx_d;
      cfg_loaded_q <= cfg_loaded_d;
      weights_q    <= weights_d;
      ising_rstn_q <= ising_rstn_d;
      settle_cnt_q <= settle_cnt_d;
      run_rem_q    <= run_rem_d;
      prev_phase_q <= prev_phase_d;
      res_valid_q  <= res_valid_d;
      res_phase_q  <= res_phase_d;
      res_flips_q  <= res_flips_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    word_idx_d   = word_idx_q;
    cfg_loaded_d = cfg_loaded_q;
    weights_d    = weights_q;
    ising_rstn_d = ising_rstn_q;
    settle_cnt_d = settle_cnt_q;
    run_rem_d    = run_rem_q;
    prev_phase_d = prev_phase_q;
    res_valid_d  = res_valid_q;
    res_phase_d  = res_phase_q;
    res_flips_d  = res_flips_q;

    unique case (state_q)
      IDLE: begin
        // Commit reads shadow_q, so a word written in the same cycle lands
        // in the shadow but not in this run's weights.
        if (start && cfg_loaded_q) begin
          weights_d    = shadow_q;
          run_rem_d    = (run_cycles == '0) ? RUN_W'(1) : run_cycles;
          res_flips_d  = '0;
          settle_cnt_d = '0;
          ising_rstn_d = 1'b0;
          state_d      = SETTLE;
        end
        if (cfg_valid) begin
          // Bits of the last word beyond WB-1 have no home and are dropped.
          for (int unsigned b = 0; b < WB; b++) begin
            if (word_idx_q == IDX_W'(b / WORD_W)) begin
              shadow_d[b] = cfg_data[DW_W'(b % WORD_W)];
            end
          end
          if (word_idx_q == LAST_IDX) begin
            word_idx_d   = '0;
            cfg_loaded_d = 1'b1;
          end else begin
            word_idx_d = word_idx_q + IDX_W'(1);
          end
        end
      end

      SETTLE: begin
        if (abort) begin
          ising_rstn_d = 1'b0;
          state_d      = IDLE;
        end else if (settle_cnt_q == LAST_SETTLE) begin
          ising_rstn_d = 1'b1;
          prev_phase_d = '0;
          state_d      = RUN;
        end else begin
          settle_cnt_d = settle_cnt_q + SC_W'(1);
        end
      end

      RUN: begin
        if (abort) begin
          ising_rstn_d = 1'b0;
          state_d      = IDLE;
        end else begin
          // Activity count: one per cycle where phase moved, saturating.
          if ((phase != prev_phase_q) && (res_flips_q != FLIP_MAX)) begin
            res_flips_d = res_flips_q + FLIP_W'(1);
          end
          prev_phase_d = phase;
          if (run_rem_q == RUN_W'(1)) begin
            res_phase_d = phase;
            res_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            run_rem_d = run_rem_q - RUN_W'(1);
          end
        end
      end

      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Handshake/status decoded from state; everything else comes from flops
  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign cfg_loaded = cfg_loaded_q;
  assign weights    = weights_q;
  assign ising_rstn = ising_rstn_q;
  assign res_valid  = res_valid_q;
  assign res_phase  = res_phase_q;
  assign res_flips  = res_flips_q;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// tb_ising_run_ctrl: randomized self-checking bench for ising_run_ctrl.
//   A cycle-level reference model predicts status outputs every cycle and
//   pushes expected results into a scoreboard; a monitor pops and compares
//   whenever a new result is presented.
module tb_ising_run_ctrl;

  localparam int N      = 3;
  localparam int NWGT   = 5;
  localparam int WORD_W = 8;
  localparam int RUN_W  = 16;
  localparam int S      = 4;
  localparam int FW     = 8;
  localparam int WB     = $clog2(NWGT) * (N * (N - 1) / 2);
  localparam int NW     = (WB + WORD_W - 1) / WORD_W;
  localparam int FMAX   = (1 << FW) - 1;
  localparam int MAXC   = 40000;

  logic              clk;
  logic              rstn;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_loaded;
  logic              start;
  logic [RUN_W-1:0]  run_cycles;
  logic              abort;
  logic              busy;
  logic [WB-1:0]     weights;
  logic              ising_rstn;
  logic [N-1:0]      phase;
  logic              res_valid;
  logic              res_ready;
  logic [N-1:0]      res_phase;
  logic [FW-1:0]     res_flips;

  ising_run_ctrl #(
    .N(N), .NUM_WEIGHTS(NWGT), .WORD_W(WORD_W), .RUN_W(RUN_W),
    .SETTLE_CYCLES(S), .FLIP_W(FW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_loaded(cfg_loaded),
    .start(start), .run_cycles(run_cycles), .abort(abort), .busy(busy),
    .weights(weights), .ising_rstn(ising_rstn), .phase(phase),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_phase(res_phase), .res_flips(res_flips)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // index of the most recent rising edge

  logic [N-1:0] hist [0:MAXC-1];   // phase driven in the interval after edge i
  int           phase_mode  = 0;   // 0 random, 1 toggle, 2 constant
  logic [N-1:0] phase_const = '0;

  typedef struct {
    int           at;
    logic [N-1:0] ph;
    int           fl;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Flip count over a window of run intervals; comparison starts from zero.
  function automatic int flips_over(input int a, input int b);
    logic [N-1:0] prev = '0;
    int cnt = 0;
    for (int i = a; i <= b; i++) begin
      if (hist[i] !== prev) cnt++;
      prev = hist[i];
    end
    return (cnt > FMAX) ? FMAX : cnt;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Phase source: new value shortly after every edge, logged per interval
  initial begin
    phase   = '0;
    hist[0] = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (phase_mode)
        0:       phase = N'($urandom);
        1:       phase = ~phase;
        default: phase = phase_const;
      endcase
      if (cyc < MAXC) hist[cyc] = phase;
    end
  end

  // Reference model: checks the current interval, then applies the events
  // that the next edge will sample.
  bit                   m_loaded, m_run, m_pend, m_rstn, m_idle, m_settle;
  int                   m_idx, m_t, m_r, m_rfl;
  logic [NW*WORD_W-1:0] m_img = '0;
  logic [WB-1:0]        m_w   = '0;
  logic [N-1:0]         m_rph = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_loaded = 0; m_run = 0; m_pend = 0; m_rstn = 0;
        m_idx = 0; m_img = '0; m_w = '0; m_rph = '0; m_rfl = 0;
        sb.delete();
      end
      m_settle = m_run && (cyc < m_t + S);
      m_idle   = !(m_run || m_pend);
      chk("busy", 32'(busy), 32'(!m_idle));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_idle));
      chk("ising_rstn", 32'(ising_rstn), 32'(m_run ? !m_settle : (m_pend ? 1'b1 : m_rstn)));
      chk("cfg_loaded", 32'(cfg_loaded), 32'(m_loaded));
      chk("weights", 32'(weights), 32'(m_w));
      chk("res_valid", 32'(res_valid), 32'(m_pend));
      if (!rstn) begin
        chk("res_phase_rst", 32'(res_phase), 32'd0);
        chk("res_flips_rst", 32'(res_flips), 32'd0);
      end
      if (m_pend) begin
        chk("res_phase_hold", 32'(res_phase), 32'(m_rph));
        chk("res_flips_hold", 32'(res_flips), 32'(m_rfl));
      end
      if (rstn) begin
        if (m_run) begin
          if (abort) begin
            m_run  = 0;
            m_rstn = 0;
          end else if (cyc == m_t + S + m_r - 1) begin
            m_run  = 0;
            m_pend = 1;
            m_rstn = 1;
            m_rph  = hist[cyc];
            m_rfl  = flips_over(m_t + S, cyc);
            sb.push_back('{cyc + 1, m_rph, m_rfl});
          end
        end else if (m_pend) begin
          if (res_ready) m_pend = 0;
        end else begin
          if (start && m_loaded) begin
            m_run = 1;
            m_t   = cyc + 1;
            m_r   = (run_cycles == '0) ? 1 : int'(run_cycles);
            m_w   = m_img[WB-1:0];
          end
          if (cfg_valid) begin
            m_img[m_idx*WORD_W +: WORD_W] = cfg_data;
            if (m_idx == NW - 1) begin
              m_idx    = 0;
              m_loaded = 1;
            end else begin
              m_idx++;
            end
          end
        end
      end
    end
  end

  // Scoreboard monitor: compare each newly presented result
  initial begin : mon
    bit   prev;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev = 0;
      end else begin
        if (res_valid && !prev) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL res_unexpected cyc=%0d got=res_valid exp=no_result", cyc);
          end else begin
            e = sb.pop_front();
            chk("res_time", 32'(cyc), 32'(e.at));
            chk("res_phase", 32'(res_phase), 32'(e.ph));
            chk("res_flips", 32'(res_flips), 32'(e.fl));
          end
        end
        prev = res_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] d);
    int n;
    bit acc;
    n = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    do begin
      acc = cfg_ready;
      tick();
      n++;
    end while (!acc && n < 500);
    chk("cfg_accept", 32'(acc), 32'd1);
    cfg_valid = 1'b0;
  endtask

  task automatic start_run(input int r);
    start      = 1'b1;
    run_cycles = RUN_W'(r);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!res_valid && n < 3000) begin
      tick();
      n++;
    end
    chk("valid_wait", 32'(res_valid), 32'd1);
  endtask

  task automatic finish_run(input int hold);
    int n;
    n = 0;
    while (busy && !res_valid && n < 3000) begin
      tick();
      n++;
    end
    chk("run_wait", 32'(n < 3000), 32'd1);
    if (res_valid) begin
      repeat (hold) tick();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, k, nw;
    rstn = 1'b0; cfg_valid = 1'b0; cfg_data = '0; start = 1'b0;
    run_cycles = '0; abort = 1'b0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_loaded", 32'(cfg_loaded), 32'd0);
    chk("rst_weights", 32'(weights), 32'd0);
    chk("rst_ising_rstn", 32'(ising_rstn), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_phase", 32'(res_phase), 32'd0);
    chk("rst_res_flips", 32'(res_flips), 32'd0);
    rstn = 1'b1;
    tick();

    // Start with no image, then with a partial image: both ignored
    start_run(5);
    tick();
    chk("busy_no_image", 32'(busy), 32'd0);
    send_word(8'hA5);
    start_run(5);
    tick();
    chk("busy_partial", 32'(busy), 32'd0);
    chk("loaded_partial", 32'(cfg_loaded), 32'd0);
    send_word(8'h01);
    chk("loaded_full", 32'(cfg_loaded), 32'd1);

    // Commit and run 10, then hold the result under back-pressure
    start_run(10);
    chk("weights_commit", 32'(weights), 32'h1A5);
    wait_valid();
    cfg_valid  = 1'b1;
    cfg_data   = 8'h3C;
    start      = 1'b1;
    run_cycles = RUN_W'(3);
    repeat (20) tick();
    chk("bp_cfg_ready", 32'(cfg_ready), 32'd0);
    start     = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("idle_after_hs", 32'(busy), 32'd0);
    chk("stalled_word_offer", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;

    // Abort in the third RUN cycle
    start_run(10);
    chk("weights_second", 32'(weights), 32'h13C);
    repeat (S + 2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rstn", 32'(ising_rstn), 32'd0);
    chk("abort_valid", 32'(res_valid), 32'd0);

    // Zero run length behaves as one
    start_run(0);
    finish_run(0);

    // Saturating flip count with a toggling phase
    phase_mode = 1;
    tick();
    start_run(300);
    wait_valid();
    chk("flips_saturate", 32'(res_flips), 32'(FMAX));
    finish_run(2);

    // Constant phase: zero, then nonzero (one flip against the cleared register)
    phase_mode  = 2;
    phase_const = 3'b000;
    tick();
    start_run(12);
    wait_valid();
    chk("flips_const0", 32'(res_flips), 32'd0);
    finish_run(0);
    phase_const = 3'b101;
    tick();
    start_run(6);
    wait_valid();
    chk("flips_const5", 32'(res_flips), 32'd1);
    chk("phase_const5", 32'(res_phase), 32'd5);
    finish_run(1);
    phase_mode = 0;

    // Word and start in the same cycle: old shadow committed, word kept
    cfg_valid = 1'b1;
    cfg_data  = 8'h00;
    start_run(2);
    cfg_valid = 1'b0;
    chk("weights_same_cycle", 32'(weights), 32'h13C);
    finish_run(0);
    start_run(1);
    chk("weights_next_run", 32'(weights), 32'h03C);
    finish_run(0);

    // Randomized runs with occasional aborts and same-cycle words
    for (int it = 0; it < 14; it++) begin
      phase_mode = int'($urandom_range(0, 1));
      nw = int'($urandom_range(0, 3));
      repeat (nw) send_word(WORD_W'($urandom));
      r = int'($urandom_range(0, 25));
      if ($urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b1;
        cfg_data  = WORD_W'($urandom);
      end
      start_run(r);
      cfg_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        k = int'($urandom_range(0, S + r + 2));
        repeat (k) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      finish_run(int'($urandom_range(0, 4)));
    end

    // Asynchronous reset in the middle of a run
    phase_mode = 0;
    start_run(20);
    repeat (S + 3) tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("arst_loaded", 32'(cfg_loaded), 32'd0);
    chk("arst_weights", 32'(weights), 32'd0);
    chk("arst_rstn", 32'(ising_rstn), 32'd0);
    chk("arst_valid", 32'(res_valid), 32'd0);
    chk("arst_phase", 32'(res_phase), 32'd0);
    chk("arst_flips", 32'(res_flips), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Recovery: shadow and index were cleared, so a fresh image is needed
    start_run(3);
    tick();
    chk("post_rst_ignored", 32'(busy), 32'd0);
    send_word(8'h5A);
    send_word(8'h00);
    start_run(3);
    chk("post_rst_weights", 32'(weights), 32'h05A);
    finish_run(0);
    repeat (3) tick();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
